// File: rtl/f11_qbus_cyc.sv
// f11_qbus_cyc: Q-bus DATI/DATO/DATOB/DATIO cycle sequencer fed by the DC304 MMU.
// Define QBUS_TOUT_EN to build the RPLY timeout counter and err_to.
module f11_qbus_cyc #(
  parameter int QB_SETUP = 2,
  parameter int QB_TOUT  = 64
) (
  input  logic        pin_clk,
  input  logic        pin_rst_n,
  input  logic        pin_mce_p,
  input  logic        pin_mce_n,
  input  logic        req_stb,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic        req_rmw,
  input  logic        req_wstb,
  input  logic [21:0] req_addr,
  input  logic        req_bs7,
  input  logic        req_de_n,
  input  logic        req_ra_n,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rdy,
  output logic        busy,
  output logic        err_to,
  output logic        err_abt,
  output logic [21:0] qb_dal_o,
  output logic        qb_dal_oe,
  input  logic [15:0] qb_dal_i,
  output logic        qb_sync,
  output logic        qb_din,
  output logic        qb_dout,
  output logic        qb_wtbt,
  output logic        qb_bs7,
  input  logic        qb_rply
);

  typedef enum logic [3:0] {
    IDLE, ADDR, SYNC, RD, RDEND, HOLD, WR, TAIL, LOCAL, ABT
  } state_t;

  state_t      state, state_nx;
  logic        rply_s1, rs;
  logic        wr_q, byte_q, rmw_q, bs7_q;
  logic [21:0] dal_q;
  logic [3:0]  scnt;
  logic        dout_r, dal_hold, rcap;
  logic        rdy_nx, abt_nx;
  logic        tout_hit, tmo;
  logic [15:0] wd;

  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      rply_s1 <= 1'b0;
      rs      <= 1'b0;
    end else begin
      rply_s1 <= qb_rply;
      rs      <= rply_s1;
    end
  end

`ifdef QBUS_TOUT_EN
  logic [9:0] tcnt;
  logic       waiting;

  assign waiting  = (state == RD) || (state == WR && dout_r);
  assign tout_hit = waiting && (tcnt >= 10'(QB_TOUT - 1));

  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      tcnt   <= '0;
      err_to <= 1'b0;
    end else if (pin_mce_p) begin
      tcnt   <= waiting ? tcnt + 10'd1 : 10'd0;
      err_to <= tmo;
    end
  end
`else
  assign tout_hit = 1'b0;
  assign err_to   = 1'b0;
`endif

  // A reply seen on the expiry tick keeps the cycle alive.
  assign tmo = tout_hit && !rs && ((state == RD && !rcap) || state == WR);

  // Byte data arrives right-justified and goes out on both lanes.
  assign wd       = byte_q ? {wdata[7:0], wdata[7:0]} : wdata;
  assign qb_dal_o = dal_q;

  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) state <= IDLE;
    else if (pin_mce_p) state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rdy_nx    = 1'b0;
    abt_nx    = 1'b0;
    qb_sync   = 1'b0;
    qb_din    = 1'b0;
    qb_dout   = 1'b0;
    qb_wtbt   = 1'b0;
    qb_bs7    = 1'b0;
    qb_dal_oe = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (req_stb) state_nx = ADDR;
      ADDR: begin
        qb_dal_oe = 1'b1;
        qb_bs7    = bs7_q;
        qb_wtbt   = wr_q;
        if (scnt == 4'd0 && !req_de_n) begin
          state_nx = ABT;
          abt_nx   = 1'b1;
        end else if (scnt == 4'd0 && !req_ra_n) begin
          state_nx = LOCAL;
          rdy_nx   = 1'b1;
        end else if (scnt == 4'(QB_SETUP - 1)) begin
          state_nx = SYNC;
        end
      end
      SYNC: begin
        qb_sync   = 1'b1;
        qb_dal_oe = 1'b1;
        qb_wtbt   = wr_q;
        state_nx  = wr_q ? WR : RD;
      end
      RD: begin
        qb_sync = 1'b1;
        qb_din  = 1'b1;
        if (rcap) begin
          state_nx = RDEND;
          rdy_nx   = 1'b1;
        end else if (tmo) begin
          state_nx = IDLE;
        end
      end
      RDEND: begin
        qb_sync  = 1'b1;
        state_nx = rmw_q ? HOLD : TAIL;
      end
      HOLD: begin
        qb_sync = 1'b1;
        qb_wtbt = 1'b1;
        if (req_wstb) state_nx = WR;
      end
      WR: begin
        qb_sync   = 1'b1;
        qb_dal_oe = 1'b1;
        qb_dout   = dout_r;
        qb_wtbt   = byte_q;
        if (dout_r && rs) begin
          state_nx = TAIL;
          rdy_nx   = 1'b1;
        end else if (tmo) begin
          state_nx = IDLE;
        end
      end
      TAIL: begin
        qb_sync   = 1'b1;
        qb_dal_oe = dal_hold;
        if (!rs) state_nx = IDLE;
      end
      LOCAL:   state_nx = IDLE;
      ABT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read data is taken on the falling-edge enable once the synchronized reply is up.
  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      rdy      <= 1'b0;
      err_abt  <= 1'b0;
      rcap     <= 1'b0;
      dal_hold <= 1'b0;
      dout_r   <= 1'b0;
      scnt     <= '0;
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      rmw_q    <= 1'b0;
      bs7_q    <= 1'b0;
      dal_q    <= '0;
      rdata    <= '0;
    end else if (pin_mce_p) begin
      rdy      <= rdy_nx;
      err_abt  <= abt_nx;
      rcap     <= 1'b0;
      dal_hold <= (state == WR);
      dout_r   <= (state == WR);
      scnt     <= (state == ADDR) ? scnt + 4'd1 : 4'd0;
      if (state == IDLE && req_stb) begin
        wr_q   <= req_wr;
        byte_q <= req_byte;
        rmw_q  <= req_rmw;
        bs7_q  <= req_bs7;
        dal_q  <= req_addr;
      end
      if ((state == SYNC && wr_q) || (state == HOLD && req_wstb))
        dal_q <= {6'd0, wd};
      if (state_nx == LOCAL)
        rdata <= '0;
    end else if (pin_mce_n && state == RD && rs && !rcap) begin
      rdata <= qb_dal_i;
      rcap  <= 1'b1;
    end
  end

endmodule
